// File: rtl/key_accum_display.sv
// rtl/key_accum_display.sv - debounced push-button accumulator with multiplexed 7-segment display
//
// Purpose:
//   Each raw active-low key is synchronised, debounced and edge-detected into
//   a one-cycle press pulse. Press pulses toggle a per-key LED and are summed,
//   weighted 2^k, into an up/down accumulator that wraps or clamps. The
//   accumulator is shown on a time-multiplexed hex display, with optional
//   leading-zero blanking.
//
// Ports:
//   clk      in   sole clock, rising edge
//   rstn     in   asynchronous active-low reset
//   key      in   [NKEYS]     raw buttons, 0 = pressed
//   down     in   count direction, 0 = add, 1 = subtract
//   clr      in   synchronous clear of the accumulator
//   press    out  [NKEYS]     one-cycle press pulse per key
//   led      out  [NKEYS]     per-key toggle LED, active-low
//   count    out  [4*NDIGITS] accumulator value
//   seg_sel  out  [NDIGITS]   digit enable, one-hot-low
//   seg_dig  out  [8]         segments {dp,g,f,e,d,c,b,a}, active-low
module key_accum_display #(
    parameter int NKEYS           = 4,
    parameter int NDIGITS         = 6,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SCAN_CYCLES     = 32768,
    parameter int SATURATE        = 0,
    parameter int LZ_BLANK        = 0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NKEYS-1:0]       key,
    input  logic                   down,
    input  logic                   clr,
    output logic [NKEYS-1:0]       press,
    output logic [NKEYS-1:0]       led,
    output logic [4*NDIGITS-1:0]   count,
    output logic [NDIGITS-1:0]     seg_sel,
    output logic [7:0]             seg_dig
);

    localparam int CW = 4 * NDIGITS;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    // Wide enough for count + delta without losing the carry, whichever is wider.
    localparam int EW = ((CW > NKEYS) ? CW : NKEYS) + 1;

    // ------------------------------------------------------------------
    // Synchroniser and debounce
    // ------------------------------------------------------------------
    logic [NKEYS-1:0] r_sync1;
    logic [NKEYS-1:0] r_sync2;
    logic [NKEYS-1:0] r_deb;
    logic [NKEYS-1:0] r_press;
    logic [NKEYS-1:0] r_led;
    logic [DW-1:0]    r_dcnt [NKEYS];
    logic [NKEYS-1:0] w_flip;

    // A key flips when this is the last of DEBOUNCE_CYCLES consecutive
    // cycles in which the synchronised level disagreed with the debounced one.
    always_comb begin
        w_flip = '0;
        for (int k = 0; k < NKEYS; k++) begin
            w_flip[k] = (r_sync2[k] != r_deb[k]) &&
                        (r_dcnt[k] == DW'(DEBOUNCE_CYCLES - 1));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_deb   <= '1;
            r_press <= '0;
            r_led   <= '1;
            for (int k = 0; k < NKEYS; k++) begin
                r_dcnt[k] <= '0;
            end
        end else begin
            r_sync1 <= key;
            r_sync2 <= r_sync1;
            // Only a 1->0 flip of the debounced level is a press.
            r_press <= w_flip & r_deb;
            r_led   <= r_led ^ r_press;
            r_deb   <= r_deb ^ w_flip;
            for (int k = 0; k < NKEYS; k++) begin
                // Agreement (a bounce back) or an accepted flip restarts the run.
                if ((r_sync2[k] == r_deb[k]) || w_flip[k]) begin
                    r_dcnt[k] <= '0;
                end else begin
                    r_dcnt[k] <= r_dcnt[k] + DW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Accumulator
    // ------------------------------------------------------------------
    logic [CW-1:0] r_count;
    logic [EW-1:0] w_cnt_ext;
    logic [EW-1:0] w_delta;
    logic [EW-1:0] w_sum;
    logic          w_under;
    logic [CW-1:0] w_diff;
    logic [CW-1:0] w_next;

    // The press vector read as a binary number is exactly sum(2^k).
    always_comb begin
        w_cnt_ext = EW'(r_count);
        w_delta   = EW'(r_press);
        w_sum     = w_cnt_ext + w_delta;
        w_under   = (w_delta > w_cnt_ext);
        // Truncating delta before subtracting is still exact modulo 2^CW.
        w_diff    = r_count - w_delta[CW-1:0];
        w_next    = r_count;
        if (down) begin
            if ((SATURATE != 0) && w_under) begin
                w_next = '0;
            end else begin
                w_next = w_diff;
            end
        end else begin
            if ((SATURATE != 0) && (w_sum[EW-1:CW] != '0)) begin
                w_next = '1;
            end else begin
                w_next = w_sum[CW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [PW-1:0]      r_pre;
    logic [IW-1:0]      r_idx;
    logic [NDIGITS-1:0] r_seg_sel;
    logic [7:0]         r_seg_dig;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (r_pre == PW'(SCAN_CYCLES - 1)) begin
            r_pre <= '0;
            if (r_idx == IW'(NDIGITS - 1)) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + IW'(1);
            end
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    logic [3:0]         w_nib;
    logic               w_upper_nz;
    logic [NDIGITS-1:0] w_sel;
    logic [6:0]         w_glyph;

    // w_upper_nz: some nibble at or above the current digit is nonzero,
    // i.e. this digit is not a leading zero.
    always_comb begin
        w_nib      = '0;
        w_upper_nz = 1'b0;
        w_sel      = '1;
        for (int d = 0; d < NDIGITS; d++) begin
            if (r_idx == IW'(d)) begin
                w_nib    = r_count[4*d +: 4];
                w_sel[d] = 1'b0;
            end
            if ((d >= int'(r_idx)) && (r_count[4*d +: 4] != 4'h0)) begin
                w_upper_nz = 1'b1;
            end
        end
    end

    always_comb begin
        w_glyph = 7'h00;
        case (w_nib)
            4'h0: w_glyph = 7'h3F;
            4'h1: w_glyph = 7'h06;
            4'h2: w_glyph = 7'h5B;
            4'h3: w_glyph = 7'h4F;
            4'h4: w_glyph = 7'h66;
            4'h5: w_glyph = 7'h6D;
            4'h6: w_glyph = 7'h7D;
            4'h7: w_glyph = 7'h07;
            4'h8: w_glyph = 7'h7F;
            4'h9: w_glyph = 7'h6F;
            4'hA: w_glyph = 7'h77;
            4'hB: w_glyph = 7'h7C;
            4'hC: w_glyph = 7'h39;
            4'hD: w_glyph = 7'h5E;
            4'hE: w_glyph = 7'h79;
            4'hF: w_glyph = 7'h71;
            default: w_glyph = 7'h00;
        endcase
    end

    // Select and segments are registered together so they never skew.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_seg_sel <= '1;
            r_seg_dig <= 8'hFF;
        end else begin
            r_seg_sel <= w_sel;
            if ((LZ_BLANK != 0) && (r_idx != '0) && !w_upper_nz) begin
                r_seg_dig <= 8'hFF;
            end else begin
                r_seg_dig <= {1'b1, ~w_glyph};
            end
        end
    end

    assign press   = r_press;
    assign led     = r_led;
    assign count   = r_count;
    assign seg_sel = r_seg_sel;
    assign seg_dig = r_seg_dig;

endmodule

// File: doc/key_accum_display.md
KEY_ACCUM_DISPLAY -- requirements
Module: key_accum_display

Interface
REQ-001 The block SHALL take parameter NKEYS, default 4, as the number of push-button channels (1..8).
REQ-002 The block SHALL take parameter NDIGITS, default 6, as the number of 7-segment digits, each showing 4 count bits.
REQ-003 The block SHALL take parameter DEBOUNCE_CYCLES, default 1000000, as the stable-input cycles required to accept a new key level.
REQ-004 The block SHALL take parameter SCAN_CYCLES, default 32768, as the clocks per digit during display scanning.
REQ-005 The block SHALL take parameter SATURATE, default 0: 0 = count wraps, 1 = count clamps.
REQ-006 The block SHALL take parameter LZ_BLANK, default 0: 1 = blank leading zero digits.
REQ-007 Port clk, input, 1, sole clock; all logic on its rising edge.
REQ-008 Port rstn, input, 1, asynchronous active-low reset.
REQ-009 Port key, input, NKEYS, raw asynchronous buttons, active-low (0 = pressed).
REQ-010 Port down, input, 1, count direction: 0 = add, 1 = subtract; sampled synchronously.
REQ-011 Port clr, input, 1, synchronous clear of count, active-high.
REQ-012 Port press, output, NKEYS, one-cycle press pulse per channel, active-high.
REQ-013 Port led, output, NKEYS, per-channel toggle LED, active-low.
REQ-014 Port count, output, 4*NDIGITS, accumulator value.
REQ-015 Port seg_sel, output, NDIGITS, digit enable, active-low, one-hot-low.
REQ-016 Port seg_dig, output, 8, segments {dp,g,f,e,d,c,b,a}, active-low.

Function
REQ-017 Each key bit SHALL pass through a 2-flop synchroniser before debouncing.
REQ-018 Debounce: the debounced level SHALL change only after the synchronised input differs from it and holds that value for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-019 press[k] SHALL be high for exactly one cycle, the cycle after debounced[k] goes 1->0; release produces no pulse.
REQ-020 led[k] SHALL toggle on the clock edge after each press[k] pulse.
REQ-021 Per cycle, delta SHALL equal the sum of 2^k over all k with press[k]=1, computed at NKEYS+1 bits; simultaneous presses sum in one update.
REQ-022 count SHALL update on the edge after press: count+delta when down=0, count-delta when down=1.
REQ-023 SATURATE=0: arithmetic SHALL be modulo 2^(4*NDIGITS).
REQ-024 SATURATE=1: add SHALL clamp at 2^(4*NDIGITS)-1 and subtract SHALL clamp at 0.
REQ-025 clr=1 SHALL force count to 0 on the next edge, overriding any simultaneous delta; led and debounce state are unaffected.
REQ-026 The scan prescaler SHALL count 0..SCAN_CYCLES-1; on wrap the digit index SHALL advance 0..NDIGITS-1, then wrap to 0.
REQ-027 seg_sel bit[idx] SHALL be 0 and all others 1; seg_dig SHALL show the hex glyph of count[4*idx+:4], inverted.
REQ-028 Glyphs (active-high, before inversion) SHALL be 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71; dp always off.
REQ-029 LZ_BLANK=1: a digit above the highest nonzero nibble SHALL output seg_dig=FF; digit 0 is never blanked.
REQ-030 seg_sel and seg_dig SHALL be registered, changing together on the same edge.

Reset
REQ-031 rstn=0 SHALL asynchronously set: count=0, led=all 1, press=0, debounced levels=1, debounce counters=0, synchronisers=1, scan prescaler=0, digit index=0, seg_sel=all 1, seg_dig=FF.
REQ-032 Reset asserted mid-debounce or mid-scan SHALL discard the partial state; no press pulse follows reset release unless a new stable press occurs.

Verification
(bench params: NKEYS=4, NDIGITS=2, DEBOUNCE_CYCLES=4, SCAN_CYCLES=2)
REQ-033 Hold key[0]=0 steady -> exactly one press[0] pulse, count=0x01, led[0]=0; release, press again -> count=0x02, led[0]=1.
REQ-034 key[1] toggled every 2 cycles for 20 cycles, then held 0 -> one press[1] pulse only after the stable hold, count +2.
REQ-035 key[0] and key[3] pressed on the same cycle, count=0xF8 -> count=0x01 (SATURATE=0) or 0xFF (SATURATE=1).
REQ-036 down=1, count=0x03, press key[2] -> 0xFF (SATURATE=0) or 0x00 (SATURATE=1); clr=1 together with a press -> count=0x00.
REQ-037 count=0x05, LZ_BLANK=1 -> seg_sel alternates 10/01 every 2 cycles; digit0 seg_dig=92, digit1 seg_dig=FF; LZ_BLANK=0 gives digit1 C0.
REQ-038 rstn pulsed low mid-debounce and mid-scan -> all outputs at REQ-031 values immediately, with no spurious press after release.
